// File: rtl/mux_scan_ctrl_if.sv
// Scan controller bus: mux select/data plus bit stream.
// master = controller side, slave = mux/consumer side.
interface mux_scan_ctrl_if #(
  parameter int SEL_W = 8
);
  logic             start;
  logic [SEL_W-1:0] first_idx;
  logic [SEL_W-1:0] last_idx;
  logic             abort;
  logic [SEL_W-1:0] sel;
  logic             mux_out;
  logic             bit_valid;
  logic             bit_ready;
  logic             bit_data;
  logic             bit_last;
  logic             busy;
  logic             done;
  logic [SEL_W:0]   bit_cnt;

  modport master (
    input  start,
    input  first_idx,
    input  last_idx,
    input  abort,
    input  mux_out,
    input  bit_ready,
    output sel,
    output bit_valid,
    output bit_data,
    output bit_last,
    output busy,
    output done,
    output bit_cnt
  );

  modport slave (
    output start,
    output first_idx,
    output last_idx,
    output abort,
    output mux_out,
    output bit_ready,
    input  sel,
    input  bit_valid,
    input  bit_data,
    input  bit_last,
    input  busy,
    input  done,
    input  bit_cnt
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps the bit-select mux over [first..last] and
// streams each sampled bit out over valid/ready.
module mux_scan_ctrl #(
  parameter int SEL_W   = 8,
  parameter int MUX_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_PRESENT
  } state_t;

  localparam logic [1:0]       LAT_C   = 2'(MUX_LAT);
  localparam logic [1:0]       SET_ONE = 2'd1;
  localparam logic [SEL_W-1:0] IDX_ONE = SEL_W'(1);
  localparam logic [SEL_W:0]   CNT_ONE = (SEL_W+1)'(1);

  state_t           r_state;
  logic [SEL_W-1:0] r_idx;
  logic [SEL_W-1:0] r_last;
  logic [1:0]       r_settle;
  logic             r_valid;
  logic             r_data;
  logic             r_lastf;
  logic             r_busy;
  logic             r_done;
  logic [SEL_W:0]   r_cnt;

  logic w_hs;
  logic w_settled;
  logic w_go;

  assign w_hs      = r_valid & bus.bit_ready;
  assign w_settled = (r_settle == LAT_C);
  assign w_go      = bus.start & ~bus.abort;

  // The mux select is owned solely by the index register.
  assign bus.sel       = r_idx;
  assign bus.bit_valid = r_valid;
  assign bus.bit_data  = r_data;
  assign bus.bit_last  = r_lastf;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.bit_cnt   = r_cnt;

  // Scan FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_last   <= '0;
      r_settle <= '0;
      r_valid  <= 1'b0;
      r_data   <= 1'b0;
      r_lastf  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_idx    <= bus.first_idx;
            r_last   <= bus.last_idx;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_settle <= '0;
            r_state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (bus.abort) begin
            r_busy   <= 1'b0;
            r_settle <= '0;
            r_state  <= S_IDLE;
          end else if (w_settled) begin
            r_data   <= bus.mux_out;
            r_valid  <= 1'b1;
            r_lastf  <= (r_idx == r_last);
            r_settle <= '0;
            r_state  <= S_PRESENT;
          end else begin
            r_settle <= r_settle + SET_ONE;
          end
        end
        S_PRESENT: begin
          // A bit accepted alongside abort still counts.
          if (w_hs) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
          if (bus.abort) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_hs) begin
            r_valid <= 1'b0;
            if (r_lastf) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_idx    <= r_idx + IDX_ONE;
              r_settle <= '0;
              r_state  <= S_SETTLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
